cordic_engine: RTL and testbench
================================

Name: cordic_engine

Overview:
- Parametrised, fully pipelined CORDIC with a per-sample rotation/vectoring mode.
- Accepts any angle over the full circle, in either mode.
- Optionally applies gain compensation so outputs need no scaling downstream.
- Uses a valid/ready stream interface with backpressure, so it can sit directly between stream producers and consumers in the DSP datapath.

Parameters:
- DATA_WIDTH, 16: signed width of x_in/y_in.
- PHASE_WIDTH, 32: angle width; binary angle, 2^PHASE_WIDTH = 2π, wraps naturally.
- STAGES, 16: micro-rotation count. Legal range 4 to min(PHASE_WIDTH-2, DATA_WIDTH+1); otherwise elaboration error.
- GAIN_COMP, 1: 1 = multiply x/y outputs by 1/An; 0 = raw (gain ≈1.6468).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: input sample valid.
- in_ready, output, 1: engine can accept a sample this cycle.
- in_mode, input, 1: 0 = rotation, 1 = vectoring.
- x_in, input, DATA_WIDTH: signed x.
- y_in, input, DATA_WIDTH: signed y.
- z_in, input, PHASE_WIDTH: rotation mode: angle to rotate by; vectoring mode: angle offset added to the result.
- out_valid, output, 1: output sample valid.
- out_ready, input, 1: consumer accepts the output.
- out_mode, output, 1: mode of the output sample.
- x_out, output, DATA_WIDTH+2: signed x result.
- y_out, output, DATA_WIDTH+2: signed y result.
- z_out, output, PHASE_WIDTH: rotation mode: residual angle (≈0); vectoring mode: z_in + atan2(y_in, x_in).

Behaviour:
- Reset: all pipeline valid bits, x_out, y_out, z_out, out_mode and out_valid go to 0. in_ready goes to 1 one cycle after rst deasserts. A reset mid-operation discards all in-flight samples; no partial output is ever emitted.
- Pipeline structure: one pre-rotation stage, then STAGES iteration stages, then one output/gain stage. Latency is STAGES+2 cycles from input handshake to out_valid when no stall occurs.
- Each stage carries a valid bit and a mode bit. Bubbles propagate as invalid entries.
- Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational). When advance=0, every register holds its value, and outputs stay stable while out_valid=1 and out_ready=0.
- Handshakes: an input is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready. With no backpressure, throughput is one sample per cycle.
- Internal x/y width is DATA_WIDTH+2; sign-extend the inputs. Shifts are arithmetic (>>>). z arithmetic is modulo 2^PHASE_WIDTH.
- Pre-rotation, rotation mode, keyed on z[PW-1:PW-2]:
  - 00 or 11: pass unchanged.
  - 01: (x,y) <- (-y,x), z <- z - 2^(PW-2).
  - 10: (x,y) <- (y,-x), z <- z + 2^(PW-2).
- Pre-rotation, vectoring mode:
  - x >= 0: pass unchanged.
  - x < 0 and y >= 0: (x,y) <- (y,-x), z <- z + 2^(PW-2).
  - x < 0 and y < 0: (x,y) <- (-y,x), z <- z - 2^(PW-2).
- Stage i (i = 0..STAGES-1): d = +1 if (rotation and z >= 0) or (vectoring and y < 0), else -1.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*atan_i
- atan_i = round(atan(2^-i) * 2^PHASE_WIDTH / (2π)). The table is built at elaboration from parameters, so no hand-entered constants. For PW=32: atan_0 = 536870912, atan_1 = 316933406.
- Output stage, GAIN_COMP=1: K = round(0.6072529350 * 2^(DATA_WIDTH+1)); x_out = (x*K) >>> (DATA_WIDTH+1), and likewise y_out. The product is full precision and the result truncates toward -inf.
- Output stage, GAIN_COMP=0: pass through.
- z_out is never compensated.
- Overflow: not possible for |x_in|, |y_in| ≤ 2^(DATA_WIDTH-1)-1. The input -2^(DATA_WIDTH-1) is legal with the same headroom.
- Vectoring with x_in = y_in = 0: x_out = y_out = 0, and z_out is deterministic but unspecified.
- Mode may change every sample; there are no bubbles between mixed-mode samples.

Test Plan:
1. Rotation, GAIN_COMP=1, x_in=16384, y_in=0, z_in=0x20000000 (π/4): out_valid exactly 18 cycles after accept; x_out and y_out = 11585 ±4; |z_out| < 2^17.
2. Quadrant corners, rotation, x_in=16384, y_in=0, tolerance ±4:
   - z_in=0x80000000 (π): x_out = -16384, y_out = 0.
   - z_in=0xC0000000 (-π/2): x_out = 0, y_out = -16384.
   - z_in=0x40000000 (π/2): x_out = 0, y_out = 16384.
3. Vectoring, GAIN_COMP=1, x_in=12000, y_in=16000, z_in=0: x_out = 20000 ±4, y_out within ±4, z_out = 633866800 ±2^16. Repeat with x_in=-12000: z_out ≈ 2^31 - 633866800.
4. Backpressure: stream 40 back-to-back samples with out_ready toggling pseudo-randomly. Required: no loss, no duplication, order preserved; outputs stable while stalled; in_ready == !out_valid || out_ready every cycle.
5. Mixed modes back-to-back, alternating rotation and vectoring every cycle: each output matches the scoreboard model, and out_mode matches the input.
6. Reset at cycle 5 of a 10-sample burst: out_valid = 0 from the reset edge, no stale outputs after release, and a fresh sample yields the correct result after 18 cycles.

Source files
------------

// File: rtl/cordic_engine.sv
// cordic_engine: fully pipelined CORDIC with a per-sample rotation/vectoring
// mode and optional gain compensation, behind a valid/ready stream.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   in_valid/ready   input handshake (in_ready = pipeline can advance)
//   in_mode          0 = rotation, 1 = vectoring
//   x_in, y_in       signed DATA_WIDTH input vector
//   z_in             binary angle (2^PHASE_WIDTH = 2*pi)
//   out_valid/ready  output handshake
//   out_mode         mode of the sample on the output
//   x_out, y_out     signed DATA_WIDTH+2 results
//   z_out            residual angle (rotation) or z_in + atan2(y,x) (vectoring)
//
// Latency is STAGES+2 cycles; one pre-rotation stage, STAGES micro-rotation
// stages and one output/gain stage. A single advance signal stalls the whole
// pipeline when the output is held by the consumer.
module cordic_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 32,
  parameter int STAGES      = 16,
  parameter int GAIN_COMP   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic [PHASE_WIDTH-1:0]       z_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_mode,
  output logic signed [DATA_WIDTH+1:0] x_out,
  output logic signed [DATA_WIDTH+1:0] y_out,
  output logic [PHASE_WIDTH-1:0]       z_out
);
  localparam int  XW = DATA_WIDTH + 2;
  localparam int  PW = PHASE_WIDTH;
  localparam real PI = 3.14159265358979323846;
  localparam logic [PW-1:0] QUARTER = {2'b01, {(PW-2){1'b0}}};
  localparam longint K_INT = longint'(0.6072529350 * (2.0 ** (DATA_WIDTH + 1)));
  localparam logic signed [XW-1:0] GAIN_K = XW'(K_INT);

  if (STAGES < 4 || STAGES > PHASE_WIDTH - 2 || STAGES > DATA_WIDTH + 1) begin : g_bad_stages
    $error("cordic_engine: STAGES=%0d outside legal range", STAGES);
  end

  // atan(2^-idx) as a binary angle, evaluated at elaboration.
  function automatic logic [PW-1:0] atan_entry(input int idx);
    real ang;
    ang = $atan(1.0 / (2.0 ** idx)) * (2.0 ** PW) / (2.0 * PI);
    return PW'(longint'(ang));
  endfunction

  // Full-precision multiply by 1/An, truncated toward -inf.
  function automatic logic signed [XW-1:0] gain_scale(input logic signed [XW-1:0] v);
    logic signed [2*XW-1:0] prod;
    prod = (2*XW)'(v) * (2*XW)'(GAIN_K);
    prod = prod >>> (DATA_WIDTH + 1);
    return prod[XW-1:0];
  endfunction

  logic advance, accept, rdy_en;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & rdy_en;
  assign accept   = in_valid & in_ready;

  // in_ready is held low for the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  logic signed [XW-1:0] x_ext, y_ext, x_pre, y_pre;
  logic [PW-1:0]        z_pre;

  always_comb begin
    x_ext = {{2{x_in[DATA_WIDTH-1]}}, x_in};
    y_ext = {{2{y_in[DATA_WIDTH-1]}}, y_in};
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = z_in;
    if (!in_mode) begin
      case (z_in[PW-1:PW-2])
        2'b01: begin
          x_pre = -y_ext;
          y_pre = x_ext;
          z_pre = z_in - QUARTER;
        end
        2'b10: begin
          x_pre = y_ext;
          y_pre = -x_ext;
          z_pre = z_in + QUARTER;
        end
        default: ;
      endcase
    end else if (x_in[DATA_WIDTH-1]) begin
      if (!y_in[DATA_WIDTH-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = z_in + QUARTER;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = z_in - QUARTER;
      end
    end
  end

  // ---- stage p0: pre-rotation into the +/-90 degree convergence range ----
  logic signed [XW-1:0] x_p0, y_p0;
  logic [PW-1:0]        z_p0;
  logic                 mode_p0, vld_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_p0 <= 1'b0;
    else if (advance) vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      x_p0    <= x_pre;
      y_p0    <= y_pre;
      z_p0    <= z_pre;
      mode_p0 <= in_mode;
    end
  end

  // ---- stages pi: micro-rotations i = 0 .. STAGES-1 ----
  for (genvar i = 0; i < STAGES; i++) begin : g_iter
    localparam logic [PW-1:0] ATAN_I = atan_entry(i);

    logic signed [XW-1:0] x_src, y_src, x_pi, y_pi;
    logic [PW-1:0]        z_src, z_pi;
    logic                 mode_src, vld_src, mode_pi, vld_pi, d_pos;

    if (i == 0) begin : g_first
      assign x_src    = x_p0;
      assign y_src    = y_p0;
      assign z_src    = z_p0;
      assign mode_src = mode_p0;
      assign vld_src  = vld_p0;
    end else begin : g_next
      assign x_src    = g_iter[i-1].x_pi;
      assign y_src    = g_iter[i-1].y_pi;
      assign z_src    = g_iter[i-1].z_pi;
      assign mode_src = g_iter[i-1].mode_pi;
      assign vld_src  = g_iter[i-1].vld_pi;
    end

    // Rotation drives z toward 0; vectoring drives y toward 0.
    assign d_pos = mode_src ? y_src[XW-1] : ~z_src[PW-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          vld_pi <= 1'b0;
      else if (advance) vld_pi <= vld_src;
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        if (d_pos) begin
          x_pi <= x_src - (y_src >>> i);
          y_pi <= y_src + (x_src >>> i);
          z_pi <= z_src - ATAN_I;
        end else begin
          x_pi <= x_src + (y_src >>> i);
          y_pi <= y_src - (x_src >>> i);
          z_pi <= z_src + ATAN_I;
        end
        mode_pi <= mode_src;
      end
    end
  end

  // ---- output stage: gain compensation and output register ----
  logic signed [XW-1:0] x_fin, y_fin, x_cmp, y_cmp;

  assign x_fin = g_iter[STAGES-1].x_pi;
  assign y_fin = g_iter[STAGES-1].y_pi;

  if (GAIN_COMP != 0) begin : g_gain
    assign x_cmp = gain_scale(x_fin);
    assign y_cmp = gain_scale(y_fin);
  end else begin : g_raw
    assign x_cmp = x_fin;
    assign y_cmp = y_fin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (advance) begin
      out_valid <= g_iter[STAGES-1].vld_pi;
      out_mode  <= g_iter[STAGES-1].mode_pi;
      x_out     <= x_cmp;
      y_out     <= y_cmp;
      z_out     <= g_iter[STAGES-1].z_pi;
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
`timescale 1ns/1ps
module tb_cordic_engine;
  localparam int  DW = 16;
  localparam int  PW = 32;
  localparam int  ST = 16;
  localparam real PI = 3.14159265358979323846;
  localparam real ZSCALE = 4294967296.0 / (2.0 * PI);
  localparam real TOL = 8.0;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_mode = 1'b0;
  logic signed [DW-1:0] x_in = '0;
  logic signed [DW-1:0] y_in = '0;
  logic [PW-1:0]        z_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_mode;
  logic signed [DW+1:0] x_out, y_out;
  logic [PW-1:0]        z_out;

  always #5 clk = ~clk;

  cordic_engine #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .STAGES(ST), .GAIN_COMP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard of expected results in acceptance order.
  bit          q_m[$];
  real         q_x[$];
  real         q_y[$];
  logic [31:0] q_z[$];
  real         q_zt[$];

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic void clear_model();
    q_m.delete(); q_x.delete(); q_y.delete(); q_z.delete(); q_zt.delete();
  endfunction

  // Ideal math: compensated rotation by the angle, or polar conversion.
  function automatic void push_expect(input bit m, input int xi, input int yi, input logic [31:0] zi);
    real th, mag;
    q_m.push_back(m);
    if (!m) begin
      th = real'(int'(zi)) / ZSCALE;
      q_x.push_back(real'(xi) * $cos(th) - real'(yi) * $sin(th));
      q_y.push_back(real'(xi) * $sin(th) + real'(yi) * $cos(th));
      q_z.push_back(32'd0);
      q_zt.push_back(131072.0);
    end else begin
      mag = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
      q_x.push_back(mag);
      q_y.push_back(0.0);
      q_z.push_back(zi + 32'(longint'($atan2(real'(yi), real'(xi)) * ZSCALE)));
      q_zt.push_back(65536.0 + 10.0 * ZSCALE / (mag + 1.0));
    end
  endfunction

  task automatic gen_sample(input bit m, output int xi, output int yi, output logic [31:0] zi);
    real mag;
    int tries;
    tries = 0;
    do begin
      xi = int'($urandom_range(0, 65535)) - 32768;
      yi = int'($urandom_range(0, 65535)) - 32768;
      mag = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
      tries++;
    end while (m && mag < 4000.0 && tries < 50);
    zi = $urandom();
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  // Sends one sample and returns when out_valid rises (or the bound expires).
  task automatic run_single(input bit m, input int xi, input int yi, input logic [31:0] zi, output int lat);
    int guard;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = m; x_in = DW'(xi); y_in = DW'(yi); z_in = zi; out_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_mode !== 1'b0 || x_out !== '0 || y_out !== '0 || z_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b mode=%b x=%0d y=%0d z=%0d, required all 0", out_valid, out_mode, x_out, y_out, z_out);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 0 during reset", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_in_ready_early: got %b, required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_rotation_basic();
    int lat;
    run_single(1'b0, 16384, 0, 32'h2000_0000, lat);
    checks++;
    if (lat !== 18) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required 18", lat);
    end
    checks++;
    if (absr(real'(x_out) - 11585.0) > 4.0 || absr(real'(y_out) - 11585.0) > 4.0 || out_mode !== 1'b0) begin
      errors++;
      $display("FAIL rot_pi4: got x=%0d y=%0d mode=%b, required 11585+-4 each, mode 0", x_out, y_out, out_mode);
    end
    checks++;
    if (absr(real'(int'(z_out))) >= 131072.0) begin
      errors++;
      $display("FAIL rot_pi4_residual: got z=%0d, required |z| < 131072", int'(z_out));
    end
    drive_idle(3);
  endtask

  task automatic test_quadrants();
    logic [31:0] zs [3] = '{32'h8000_0000, 32'hC000_0000, 32'h4000_0000};
    int          ex [3] = '{-16384, 0, 0};
    int          ey [3] = '{0, -16384, 16384};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_single(1'b0, 16384, 0, zs[k], lat);
      checks++;
      if (lat !== 18 || absr(real'(x_out) - real'(ex[k])) > 4.0 || absr(real'(y_out) - real'(ey[k])) > 4.0) begin
        errors++;
        $display("FAIL quadrant[%0d]: got x=%0d y=%0d lat=%0d, required x=%0d y=%0d (+-4) lat=18",
                 k, x_out, y_out, lat, ex[k], ey[k]);
      end
      drive_idle(2);
    end
  endtask

  task automatic test_vectoring();
    int          xs [2] = '{12000, -12000};
    longint      zx [2] = '{633866800, 64'd2147483648 - 633866800};
    int lat;
    longint zd;
    for (int k = 0; k < 2; k++) begin
      run_single(1'b1, xs[k], 16000, 32'd0, lat);
      zd = longint'(z_out) - zx[k];
      checks++;
      if (absr(real'(x_out) - 20000.0) > 4.0 || absr(real'(y_out)) > 4.0 || out_mode !== 1'b1 ||
          absr(real'(zd)) > 65536.0) begin
        errors++;
        $display("FAIL vectoring[%0d]: got x=%0d y=%0d z=%0d mode=%b, required x=20000 y=0 (+-4) z=%0d (+-65536) mode 1",
                 k, x_out, y_out, z_out, out_mode, zx[k]);
      end
      drive_idle(2);
    end
  endtask

  task automatic test_extremes();
    bit          ms [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          xs [4] = '{-32768, -32768, -32768, -32768};
    int          ys [4] = '{32767, -32768, -32768, 0};
    logic [31:0] zs [4] = '{32'h6000_0000, 32'hA123_4567, 32'd0, 32'h1234_5678};
    int lat, zd;
    for (int k = 0; k < 4; k++) begin
      clear_model();
      push_expect(ms[k], xs[k], ys[k], zs[k]);
      run_single(ms[k], xs[k], ys[k], zs[k], lat);
      zd = int'(z_out - q_z[0]);
      checks++;
      if (lat !== 18 || out_mode !== q_m[0] || absr(real'(x_out) - q_x[0]) > TOL ||
          absr(real'(y_out) - q_y[0]) > TOL || absr(real'(zd)) > q_zt[0]) begin
        errors++;
        $display("FAIL extreme[%0d]: got x=%0d y=%0d zerr=%0d lat=%0d, required x=%.1f y=%.1f",
                 k, x_out, y_out, zd, lat, q_x[0], q_y[0]);
      end
      drive_idle(2);
    end
  endtask

  // Random stream; bp=1 toggles out_ready, alt=1 alternates modes per sample.
  task automatic test_stream(input string name, input int n, input bit bp, input bit alt);
    int sent, got, cyc, xi, yi, zd, extra, ready_low;
    bit pend, m, stall_prev;
    logic [31:0] zi;
    logic [69:0] saved;
    real ex, ey, ezt;
    logic [31:0] ez;
    bit em;
    sent = 0; got = 0; cyc = 0; pend = 0; stall_prev = 0; ready_low = 0; m = 0;
    xi = 0; yi = 0; zi = '0; saved = '0;
    clear_model();
    while (got < n && cyc < 3000) begin
      @(posedge clk); #1;
      if (!pend && sent < n) begin
        m = alt ? sent[0] : 1'($urandom_range(0, 1));
        gen_sample(m, xi, yi, zi);
        pend = 1'b1;
      end
      in_valid = pend; in_mode = m; x_in = DW'(xi); y_in = DW'(yi); z_in = zi;
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (bp) begin
        checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
          errors++;
          $display("FAIL %s in_ready cycle %0d: got %b, required %b", name, cyc, in_ready, !out_valid || out_ready);
        end
        if (stall_prev) begin
          checks++;
          if ({out_valid, out_mode, x_out, y_out, z_out} !== saved) begin
            errors++;
            $display("FAIL %s stall_hold cycle %0d: got %h, required %h", name, cyc,
                     {out_valid, out_mode, x_out, y_out, z_out}, saved);
          end
        end
        stall_prev = out_valid && !out_ready;
        saved = {out_valid, out_mode, x_out, y_out, z_out};
      end else if (!in_ready) begin
        ready_low++;
      end
      if (in_valid && in_ready) begin
        push_expect(m, xi, yi, zi);
        pend = 1'b0;
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q_x.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_output: got x=%0d, required no output", name, x_out);
        end else begin
          ex = q_x.pop_front(); ey = q_y.pop_front(); ez = q_z.pop_front();
          ezt = q_zt.pop_front(); em = q_m.pop_front();
          zd = int'(z_out - ez);
          if (out_mode !== em || absr(real'(x_out) - ex) > TOL || absr(real'(y_out) - ey) > TOL ||
              absr(real'(zd)) > ezt) begin
            errors++;
            $display("FAIL %s sample %0d: got x=%0d y=%0d zerr=%0d mode=%b, required x=%.1f y=%.1f |zerr|<=%.0f mode=%b",
                     name, got, x_out, y_out, zd, out_mode, ex, ey, ezt, em);
          end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++;
    if (got != n || sent != n || q_x.size() != 0 || extra != 0) begin
      errors++;
      $display("FAIL %s completion: got=%0d sent=%0d left=%0d extra=%0d, required %0d/%0d/0/0",
               name, got, sent, q_x.size(), extra, n, n);
    end
    if (!bp) begin
      checks++;
      if (ready_low != 0 || cyc > n + 20) begin
        errors++;
        $display("FAIL %s throughput: ready_low=%0d cycles=%0d, required 0 and <= %0d", name, ready_low, cyc, n + 20);
      end
    end
  endtask

  task automatic test_mid_reset(input int n, input int rcyc);
    int xi, yi, lat, seen, zd;
    logic [31:0] zi;
    for (int c = 0; c < rcyc; c++) begin
      @(posedge clk); #1;
      gen_sample(1'b0, xi, yi, zi);
      in_valid = (c < n); in_mode = 1'b0; x_in = DW'(xi); y_in = DW'(yi); z_in = zi; out_ready = 1'b1;
    end
    @(posedge clk); #2;
    if (rcyc >= 19) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_busy: out_valid=%b before reset, required 1", out_valid);
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || x_out !== '0 || y_out !== '0 || z_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: valid=%b ready=%b x=%0d y=%0d z=%0d, required all 0",
               out_valid, in_ready, x_out, y_out, z_out);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_stale: %0d stale output cycles, required 0", seen);
    end
    clear_model();
    push_expect(1'b0, 10000, -5000, 32'h3000_0000);
    run_single(1'b0, 10000, -5000, 32'h3000_0000, lat);
    zd = int'(z_out - q_z[0]);
    checks++;
    if (lat !== 18 || absr(real'(x_out) - q_x[0]) > TOL || absr(real'(y_out) - q_y[0]) > TOL ||
        absr(real'(zd)) > q_zt[0]) begin
      errors++;
      $display("FAIL mid_reset_fresh: got x=%0d y=%0d lat=%0d, required x=%.1f y=%.1f lat=18",
               x_out, y_out, lat, q_x[0], q_y[0]);
    end
    drive_idle(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation_basic();
    test_quadrants();
    test_vectoring();
    test_extremes();
    test_stream("backpressure", 40, 1'b1, 1'b0);
    test_stream("mixed", 24, 1'b0, 1'b1);
    test_mid_reset(10, 5);
    test_mid_reset(20, 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
